// File: rtl/package_framer_pkg.sv
// Shared definitions for the byte-stream framer and the threshold cutter
// that consumes its packages.
package package_framer_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Package width in bits; the cutter uses the same helper so both ends agree.
  function automatic int unsigned package_width(input int unsigned num);
    return num << 3;
  endfunction

endpackage

// File: rtl/package_framer_if.sv
// Byte input and package output bundle between the receive front end,
// the framer and the threshold cutter.
interface package_framer_if
  import package_framer_pkg::*;
#(
  parameter int unsigned PACKAGE_NUM = 4
) ();

  localparam int unsigned PW = package_width(PACKAGE_NUM);

  logic [7:0]    byte_i;
  logic          byte_valid;
  logic [PW-1:0] package_o;
  logic          package_wen;
  logic          frame_err;
  logic [15:0]   drop_cnt;

  modport master (
    output byte_i, byte_valid,
    input  package_o, package_wen, frame_err, drop_cnt
  );

  modport slave (
    input  byte_i, byte_valid,
    output package_o, package_wen, frame_err, drop_cnt
  );

endinterface

// File: rtl/package_framer_frame_timeout.sv
// Inter-byte idle counter. Counts clk cycles while enabled and not cleared;
// expired fires when the count sits at TIMEOUT_CYCLES-1 and no clear arrives.
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Idle counter: held at zero while disabled, restarted by every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cnt <= '0;
    else if (!i_en || i_clr || r_cnt == LAST) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + 1'b1;
  end

  // A byte in the same cycle clears the counter and suppresses expiry.
  assign o_expired = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/package_framer.sv
// Header-synchronised framer: collects PACKAGE_NUM data bytes after HEADER,
// verifies an 8-bit additive checksum and publishes good packages; bad or
// stalled frames are dropped, flagged and counted.
module package_framer
  import package_framer_pkg::*;
#(
  parameter int unsigned PACKAGE_NUM    = 4,
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             rst_n,
  package_framer_if.slave bus
);

  localparam int unsigned   PW       = package_width(PACKAGE_NUM);
  localparam int unsigned   IW       = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PACKAGE_NUM - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_sum;
  logic [PW-1:0] r_shadow;
  logic [PW-1:0] r_package;
  logic          r_wen;
  logic          r_err;
  logic [15:0]   r_drop;

  logic w_in_frame;
  logic w_accept;
  logic w_start;
  logic w_good;
  logic w_bad;
  logic w_expired;

  assign w_in_frame = (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_accept   = w_in_frame && bus.byte_valid;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_in_frame),
    .i_clr     (w_accept),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus frame start / good / bad decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.byte_valid && bus.byte_i == HEADER) begin
          w_start     = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.byte_valid) begin
          if (r_idx == LAST_IDX) w_state_nxt = ST_CHECK;
        end else if (w_expired) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bus.byte_valid) begin
          w_good      = (bus.byte_i == r_sum);
          w_bad       = (bus.byte_i != r_sum);
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shadow buffer, checksum, published package, pulses and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_sum     <= '0;
      r_shadow  <= '0;
      r_package <= '0;
      r_wen     <= 1'b0;
      r_err     <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_wen <= w_good;
      r_err <= w_bad;
      if (w_start) begin
        r_idx <= '0;
        r_sum <= '0;
      end
      if (r_state == ST_DATA && bus.byte_valid) begin
        r_shadow[8*r_idx +: 8] <= bus.byte_i;
        r_sum                  <= r_sum + bus.byte_i;
        r_idx                  <= r_idx + 1'b1;
      end
      if (w_good) r_package <= r_shadow;
      if (w_bad && r_drop != '1) r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.package_o   = r_package;
  assign bus.package_wen = r_wen;
  assign bus.frame_err   = r_err;
  assign bus.drop_cnt    = r_drop;

endmodule

// File: doc/package_framer.md
# package_framer

Byte-stream framer that sits directly upstream of the threshold cutter in the EMG acquisition path. It consumes raw sensor bytes from the receive front end and locates frames by a fixed header byte. It verifies a per-frame checksum and emits one `PACKAGE_NUM`-byte package per good frame on the `package_o`/`package_wen` pair that the cutter ingests. Bad or stalled frames are dropped, flagged and counted; they never reach the cutter.

## Interface
- `PACKAGE_NUM`, 4: data bytes per frame, one per channel; package width = `PACKAGE_NUM*8`.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 50000: maximum idle clk cycles allowed between bytes inside a frame.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `byte_i` in 8: received byte.
- `byte_valid` in 1: `byte_i` is valid this cycle; single-cycle qualifier, no back-pressure.
- `package_o` out `PACKAGE_NUM*8`: last good package. Data byte k (0-based) occupies bits [8k+7:8k].
- `package_wen` out 1: one-cycle pulse when `package_o` holds a new good package.
- `frame_err` out 1: one-cycle pulse on a checksum failure or a timeout.
- `drop_cnt` out 16: count of dropped frames, saturating.

## Operation
- FSM states and transitions:
  - IDLE: wait for `byte_valid` with `byte_i == HEADER` → DATA, clear byte index and checksum. Any other byte is ignored.
  - DATA: each valid byte is stored at slot `idx`, added to the 8-bit checksum (wraps mod 256), and increments `idx`. After byte `PACKAGE_NUM-1` → CHECK.
  - CHECK: the next valid byte is compared with the checksum.
    - Equal: copy the shadow buffer to `package_o`, pulse `package_wen`, → IDLE.
    - Not equal: pulse `frame_err`, increment `drop_cnt`, → IDLE.
- Data bytes land in a shadow buffer. `package_o` changes only on a good frame and holds its value otherwise.
- A header value received in DATA or CHECK is treated as ordinary data or checksum. There is no mid-frame resync.
- Timeout: the counter is active only in DATA and CHECK. It clears on every accepted byte and on entry to DATA.
  - When it reaches `TIMEOUT_CYCLES-1` with no byte: pulse `frame_err`, increment `drop_cnt`, → IDLE.
  - If a byte arrives in the same cycle the timeout fires, the byte wins and no timeout occurs.
- `drop_cnt` saturates at 16'hFFFF and never wraps.
- `package_wen` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values: state IDLE; `package_o` = 0; `package_wen` = 0; `frame_err` = 0; `drop_cnt` = 0; checksum, index and timeout counter = 0.
- Latency: `package_wen` and the new `package_o` are registered and appear on the cycle after the clk edge that samples the valid checksum byte. `frame_err` has the same one-cycle latency.
- Back-to-back frames: the header may arrive the cycle immediately after the checksum byte. It is accepted, since the FSM is already in IDLE.
- Reset asserted mid-frame discards the partial frame immediately. No pulse is emitted and `drop_cnt` is cleared.
- Throughput: one byte per clk; no input cycle is ever lost.

## Structure
- The shared package holds:
  - default `HEADER` value;
  - FSM state encoding (IDLE=2'd0, DATA=2'd1, CHECK=2'd2);
  - the package-width expression `PACKAGE_NUM<<3`, shared with the threshold cutter so both ends agree on width.
- One sub-module: `frame_timeout`. It holds the enable/clear inter-byte counter, is parameterized by `TIMEOUT_CYCLES`, and outputs a single `expired` pulse. All FSM, buffer and checksum logic stays in `package_framer`.

## Test plan
- Good frame: A5 01 02 03 04 0A, one byte per cycle → one `package_wen` pulse, `package_o` = 32'h04030201, `frame_err` stays 0.
- Bad checksum: A5 01 02 03 04 0B → `frame_err` pulse, `drop_cnt` = 1, no `package_wen`, `package_o` unchanged from the previous test.
- Noise and embedded header: 00 FF 13 then A5 A5 A5 A5 A5 94 → the leading bytes are ignored; the header inside the frame is taken as data; `package_o` = 32'hA5A5A5A5 with `package_wen`.
- Timeout, with `TIMEOUT_CYCLES` = 16:
  - A5 01 02 then silence → `frame_err` exactly 16 cycles after byte 02 is sampled, `drop_cnt` increments, FSM back in IDLE.
  - Repeat with byte 03 arriving on cycle 15 → no error, and the frame completes normally.
- Reset mid-frame and saturation:
  - A5 01 then `rst_n` low for 2 cycles, then 02 03 04 0A → no `package_wen`, all outputs 0.
  - Preload `drop_cnt` near full via 65537 bad frames → `drop_cnt` holds 16'hFFFF.
